// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b LSB first, one bit per clock, with an IDLE/RUN/DONE FSM.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN; otherwise ovf is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, busy_q, done_q, borrow_q;
  logic             bit_d, br_d, last_bit;

  // After WIDTH-1 right shifts, bit 0 of each operand register holds its sign bit.
  always_comb begin
    bit_d    = a_q[0] ^ b_q[0] ^ br_q;
    br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= {bit_d, diff_q[WIDTH-1:1]};
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            borrow_q <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
`endif
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`else
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed expected results.
// ovf expectations follow SERIAL_SUB_OVF_EN, matching however the design is built.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, borrow_out, ovf;
  logic [7:0] diff;

  int unsigned errors = 0;
  int unsigned checks = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf_exp(input logic v);
`ifdef SERIAL_SUB_OVF_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // One operation from accept edge k; optionally re-pulses start with other operands at k+3.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input bit inject);
    int unsigned bc, dc;
    bc = 0;
    dc = 0;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy) bc++;
      if (done) dc++;
      if (inject && i == 2) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
      end else if (inject && i == 3) begin
        start = 1'b0;
      end else if (!inject && i == 1) begin
        a = ~av;
        b = ~bv;
      end
      tick();
    end
    chk({tag, "_busy_cycles"}, bc, 8);
    chk({tag, "_early_done"}, dc, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow_out, eb);
    chk({tag, "_ovf"}, ovf, ovf_exp(eo));
    tick();
    chk({tag, "_done_one_cycle"}, done, 0);
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) dc++;
      tick();
    end
    chk({tag, "_quiet_after"}, dc, 0);
    chk({tag, "_diff_hold"}, diff, ed);
    chk({tag, "_borrow_hold"}, borrow_out, eb);
  endtask

  initial begin
    int unsigned dcount, first_done, last_done, coincide;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_ovf", ovf, 0);

    // start in the first cycle after reset release is accepted
    rst = 1'b0;
    run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    run_op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op("sub_FF_00", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("ignore_start", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    run_op("sub_7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);

    // reset asserted at edge k+4 of a running op
    a = 8'h03;
    b = 8'h05;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 8'h00);
    chk("abort_borrow", borrow_out, 0);
    chk("abort_ovf", ovf, 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    chk("abort_no_done", dcount, 0);

    // reset overrides a simultaneous start
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk("rst_over_start", busy, 0);
    start = 1'b0;
    rst = 1'b0;
    run_op("after_abort", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);

    // start held high: one op every WIDTH+2 cycles
    a = 8'h05;
    b = 8'h03;
    start = 1'b1;
    dcount = 0;
    first_done = 0;
    last_done = 0;
    coincide = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy && done) coincide++;
      if (done) begin
        if (dcount == 0) first_done = i;
        last_done = i;
        dcount++;
      end
    end
    start = 1'b0;
    chk("held_done_count", dcount, 3);
    chk("held_first_done", first_done, 8);
    chk("held_period", last_done - first_done, 20);
    chk("held_coincide", coincide, 0);
    chk("held_diff", diff, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to subtract; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 SHALL have port borrow_out  output  1  final borrow; 1 when a<b unsigned.
REQ-011 SHALL have port ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture a and b into shift registers, clear borrow FF and bit counter, and enter RUN.
REQ-014 RUN: each cycle SHALL process one bit, LSB first: d=a_i^b_i^br; br_next=(~a_i&b_i)|(~(a_i^b_i)&br).
REQ-015 Each processed bit SHALL shift into diff from the MSB end so that diff holds the full result after WIDTH RUN cycles.
REQ-016 RUN SHALL last exactly WIDTH cycles, tracked by a counter of width clog2(WIDTH)+1; it SHALL then enter DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency: start accepted at edge k -> busy=1 from k to k+WIDTH; done=1 between edges k+WIDTH and k+WIDTH+1.
REQ-019 borrow_out SHALL update only on entry to DONE.
REQ-020 diff and borrow_out SHALL then hold until the next accepted start.
REQ-021 diff SHALL be undefined-free but non-final during RUN; consumers use it only when done=1 or later.
REQ-022 start asserted in RUN or DONE SHALL be ignored; there is no queueing.
REQ-023 a and b changing after acceptance SHALL NOT affect the result in progress.
REQ-024 start held high continuously SHALL start a new operation in the first IDLE cycle after DONE, giving one op every WIDTH+2 cycles.
REQ-025 busy and done SHALL never be high in the same cycle.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, overriding start and any in-progress operation.
REQ-027 Reset values: busy=0, done=0, diff=0, borrow_out=0, ovf=0, counter=0, borrow FF=0.
REQ-028 An operation aborted by reset SHALL produce no done pulse.
REQ-029 start sampled in the first cycle after rst deasserts SHALL be accepted.

Configuration
REQ-030 Macro SERIAL_SUB_OVF_EN defined: on entry to DONE, ovf SHALL equal (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operands. ovf SHALL then hold like diff.
REQ-031 Macro SERIAL_SUB_OVF_EN undefined: ovf SHALL be constant 0, no sign-capture logic SHALL be synthesized, and the port list SHALL be unchanged.

Verification (WIDTH=8)
REQ-032 a=0x05, b=0x03, start pulse at edge k -> done at k+8, diff=0x02, borrow_out=0, busy high for 8 cycles.
REQ-033 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. a=0x00, b=0x00 -> diff=0x00, borrow_out=0.
REQ-034 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1 with SERIAL_SUB_OVF_EN and ovf=0 without it. a=0x7F, b=0xFF -> diff=0x80, ovf=1 (macro on).
REQ-035 start re-pulsed with a=0xFF, b=0x00 at cycle k+3 of a running 0x05-0x03 op -> ignored, result 0x02, single done pulse.
REQ-036 rst asserted at k+4 mid-operation -> IDLE next cycle, all outputs 0, no done pulse; a new start then gives the correct result.
REQ-037 start held high for 30 cycles -> done pulses every 10 cycles, busy/done never coincident.
